// File: rtl/prog_counter_pkg.sv
// Shared types and constants for the programmable up/down counter.
package prog_counter_pkg;

  typedef enum logic [1:0] {
    UP_WRAP = 2'b00,
    DN_WRAP = 2'b01,
    BOUNCE  = 2'b10,
    HOLD    = 2'b11
  } cnt_mode_e;

  localparam logic DIR_UP = 1'b0;
  localparam logic DIR_DN = 1'b1;

endpackage

// File: rtl/prog_counter_prescaler.sv
// Enable prescaler: emits one tick every div+1 enabled cycles; clr restarts the period.
// Only instantiated when UDC_PRESCALE_EN is defined.
module prog_counter_prescaler #(
  parameter int unsigned PRESC_W = 8
) (
  input  logic               clk,
  input  logic               asyn_rstn,
  input  logic               enb,
  input  logic               clr,
  input  logic [PRESC_W-1:0] div,
  output logic               tick
);

  logic [PRESC_W-1:0] cnt_q;

  // Wrap on >= so a div lowered below the running count recovers at once.
  always_ff @(posedge clk or negedge asyn_rstn) begin
    if (!asyn_rstn) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (enb) begin
      cnt_q <= (cnt_q >= div) ? '0 : cnt_q + 1'b1;
    end
  end

  assign tick = enb && !clr && (cnt_q == div);

endmodule

// File: rtl/prog_updown_counter.sv
// Programmable up/down counter: wrap-up, wrap-down, bounce and hold modes with bounds and step.
// Optional enable prescaler is built when UDC_PRESCALE_EN is defined.
module prog_updown_counter
  import prog_counter_pkg::*;
#(
  parameter int unsigned     WIDTH   = 4,
  parameter int unsigned     STEP_W  = 2,
  parameter logic [WIDTH-1:0] RST_VAL = '0
`ifdef UDC_PRESCALE_EN
  ,
  parameter int unsigned     PRESC_W = 8
`endif
) (
  input  logic              clk,
  input  logic              asyn_rstn,
  input  logic              enb,
  input  logic              load,
  input  logic [WIDTH-1:0]  data_in,
  input  logic [1:0]        mode,
  input  logic [WIDTH-1:0]  lim_lo,
  input  logic [WIDTH-1:0]  lim_hi,
  input  logic [STEP_W-1:0] step,
`ifdef UDC_PRESCALE_EN
  input  logic [PRESC_W-1:0] presc_div,
`endif
  output logic [WIDTH-1:0]  count,
  output logic              dir,
  output logic              tc,
  output logic              cfg_err
);

  localparam int unsigned SW = WIDTH + 1;

  logic             tick;
  logic             advance;
  cnt_mode_e        mode_e;
  logic [SW-1:0]    step_ext, cnt_ext, hi_ext, up_sum, lo_sum;
  logic [WIDTH-1:0] dn_val;
  logic [WIDTH-1:0] count_d;
  logic             dir_d, tc_d, cfg_err_d;

`ifdef UDC_PRESCALE_EN
  prog_counter_prescaler #(
    .PRESC_W (PRESC_W)
  ) u_presc (
    .clk       (clk),
    .asyn_rstn (asyn_rstn),
    .enb       (enb),
    .clr       (load),
    .div       (presc_div),
    .tick      (tick)
  );
`else
  assign tick = enb;
`endif

  // One extra bit keeps count+step and lim_lo+step from overflowing in the compares.
  assign step_ext = SW'(step);
  assign cnt_ext  = {1'b0, count};
  assign hi_ext   = {1'b0, lim_hi};
  assign up_sum   = cnt_ext + step_ext;
  assign lo_sum   = {1'b0, lim_lo} + step_ext;
  assign dn_val   = count - WIDTH'(step);
  assign mode_e   = cnt_mode_e'(mode);
  assign advance  = tick && (step != '0) && (mode_e != HOLD);

  always_comb begin
    count_d   = count;
    dir_d     = dir;
    tc_d      = 1'b0;
    cfg_err_d = (lim_lo > lim_hi);
    if (load) begin
      count_d = data_in;
    end else if (!cfg_err && advance) begin
      unique case (mode_e)
        UP_WRAP: begin
          dir_d = DIR_UP;
          if (up_sum > hi_ext) begin
            count_d = lim_lo;
            tc_d    = 1'b1;
          end else begin
            count_d = up_sum[WIDTH-1:0];
          end
        end
        DN_WRAP: begin
          dir_d = DIR_DN;
          if (cnt_ext < lo_sum) begin
            count_d = lim_hi;
            tc_d    = 1'b1;
          end else begin
            count_d = dn_val;
          end
        end
        BOUNCE: begin
          if (dir == DIR_UP) begin
            if (up_sum >= hi_ext) begin
              count_d = lim_hi;
              dir_d   = DIR_DN;
              tc_d    = 1'b1;
            end else begin
              count_d = up_sum[WIDTH-1:0];
            end
          end else begin
            if (cnt_ext <= lo_sum) begin
              count_d = lim_lo;
              dir_d   = DIR_UP;
              tc_d    = 1'b1;
            end else begin
              count_d = dn_val;
            end
          end
        end
        HOLD: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge asyn_rstn) begin
    if (!asyn_rstn) begin
      count   <= RST_VAL;
      dir     <= DIR_UP;
      tc      <= 1'b0;
      cfg_err <= 1'b0;
    end else begin
      count   <= count_d;
      dir     <= dir_d;
      tc      <= tc_d;
      cfg_err <= cfg_err_d;
    end
  end

endmodule
